// File: rtl/cmd_pkg.sv
// Shared command format, opcode set and region-overlap helper for the command issuer.
package cmd_pkg;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 4;

  typedef enum logic [ADDR_W-1:0] {
    OP_NOP = 10'd0,
    OP_ADD = 10'd1,
    OP_MUL = 10'd2,
    OP_MAC = 10'd3
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  // Half-open regions [lo, lo+len); end computed one bit wider so it never wraps.
  // An empty region overlaps nothing.
  function automatic logic regions_overlap(input logic [ADDR_W-1:0] lo_a,
                                           input logic [LEN_W-1:0]  len_a,
                                           input logic [ADDR_W-1:0] lo_b,
                                           input logic [LEN_W-1:0]  len_b);
    logic [ADDR_W:0] hi_a;
    logic [ADDR_W:0] hi_b;
    hi_a = {1'b0, lo_a} + {{(ADDR_W+1-LEN_W){1'b0}}, len_a};
    hi_b = {1'b0, lo_b} + {{(ADDR_W+1-LEN_W){1'b0}}, len_b};
    return (len_a != '0) && (len_b != '0) &&
           ({1'b0, lo_a} < hi_b) && ({1'b0, lo_b} < hi_a);
  endfunction

endpackage

// File: rtl/cmd_issuer_if.sv
// Command-FIFO and processing-unit pool signals seen by the issuer.
interface cmd_issuer_if
  import cmd_pkg::*;
#(
  parameter int NUM_UNITS = 4
);
  cmd_t                 queue_cmd;
  logic                 queue_empty;
  logic                 issuer_rd_queue;
  logic [NUM_UNITS-1:0] o_unit_valid;
  cmd_t                 o_unit_cmd;
  logic [NUM_UNITS-1:0] i_unit_done;
  logic                 finished_task;
  logic [31:0]          o_stall_cycles;

  modport master (
    input  queue_cmd, queue_empty, i_unit_done,
    output issuer_rd_queue, o_unit_valid, o_unit_cmd, finished_task, o_stall_cycles
  );

  modport slave (
    output queue_cmd, queue_empty, i_unit_done,
    input  issuer_rd_queue, o_unit_valid, o_unit_cmd, finished_task, o_stall_cycles
  );
endinterface

// File: rtl/issue_scoreboard.sv
// In-flight table, one entry per processing unit: hazard check against the held
// command, lowest-free-entry search, and completion clearing.
module issue_scoreboard
  import cmd_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  localparam int IDX_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [ADDR_W-1:0]    i_src_a,
  input  logic [ADDR_W-1:0]    i_src_b,
  input  logic [ADDR_W-1:0]    i_dst,
  input  logic [LEN_W-1:0]     i_len,
  input  logic                 i_alloc,
  input  logic [IDX_W-1:0]     i_alloc_idx,
  input  logic [NUM_UNITS-1:0] i_done,
  output logic                 o_hazard,
  output logic [IDX_W-1:0]     o_free_idx,
  output logic                 o_free_valid,
  output logic                 o_busy
);

  logic [NUM_UNITS-1:0] valid_q;
  logic [NUM_UNITS-1:0] valid_next;
  logic [ADDR_W-1:0]    src_a_q [NUM_UNITS];
  logic [ADDR_W-1:0]    src_b_q [NUM_UNITS];
  logic [ADDR_W-1:0]    dst_q   [NUM_UNITS];
  logic [LEN_W-1:0]     len_q   [NUM_UNITS];

  // Allocation only ever targets a free entry, so it cannot collide with a real done.
  always_comb begin
    valid_next = valid_q & ~i_done;
    if (i_alloc) valid_next[i_alloc_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q <= '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
        src_a_q[k] <= '0;
        src_b_q[k] <= '0;
        dst_q[k]   <= '0;
        len_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_next;
      if (i_alloc) begin
        src_a_q[i_alloc_idx] <= i_src_a;
        src_b_q[i_alloc_idx] <= i_src_b;
        dst_q[i_alloc_idx]   <= i_dst;
        len_q[i_alloc_idx]   <= i_len;
      end
    end
  end

  always_comb begin
    o_hazard = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (valid_q[k] &&
          (regions_overlap(dst_q[k], len_q[k], i_src_a, i_len) ||
           regions_overlap(dst_q[k], len_q[k], i_src_b, i_len) ||
           regions_overlap(i_dst, i_len, src_a_q[k], len_q[k]) ||
           regions_overlap(i_dst, i_len, src_b_q[k], len_q[k]) ||
           regions_overlap(i_dst, i_len, dst_q[k], len_q[k])))
        o_hazard = 1'b1;
    end
  end

  always_comb begin
    o_free_valid = 1'b0;
    o_free_idx   = '0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (!valid_q[k]) begin
        o_free_valid = 1'b1;
        o_free_idx   = IDX_W'(k);
      end
    end
  end

  assign o_busy = |valid_q;

endmodule

// File: rtl/cmd_issuer.sv
// Pops commands from the FIFO, stalls on region hazards or a full pool, and
// dispatches in order to the lowest-numbered free processing unit.
//
// state   | meaning
// S_FETCH | waiting for a non-empty FIFO; pops and latches the head
// S_HOLD  | holding one command until it can dispatch (NOPs retire directly)
module cmd_issuer
  import cmd_pkg::*;
#(
  parameter int NUM_UNITS = 4
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  cmd_issuer_if.master bus
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]           state_q;
  logic                 active_q;
  logic                 seen_q;
  cmd_t                 held_q;
  logic [31:0]          stall_q;
  logic                 fin_q;

  logic                 hazard;
  logic [IDX_W-1:0]     free_idx;
  logic                 free_valid;
  logic                 busy;

  logic                 pop;
  logic                 in_hold;
  logic                 is_nop;
  logic                 dispatch;
  logic                 stall;
  logic [NUM_UNITS-1:0] unit_valid;

  issue_scoreboard #(.NUM_UNITS(NUM_UNITS)) u_scoreboard (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_src_a      (held_q.src_a),
    .i_src_b      (held_q.src_b),
    .i_dst        (held_q.dst),
    .i_len        (held_q.len),
    .i_alloc      (dispatch),
    .i_alloc_idx  (free_idx),
    .i_done       (bus.i_unit_done),
    .o_hazard     (hazard),
    .o_free_idx   (free_idx),
    .o_free_valid (free_valid),
    .o_busy       (busy)
  );

  // active_q keeps the pop strobe low while reset is asserted and for the first edge after.
  assign pop      = active_q && (state_q == S_FETCH) && !bus.queue_empty;
  assign in_hold  = (state_q == S_HOLD);
  assign is_nop   = (held_q.op == OP_NOP);
  assign dispatch = in_hold && !is_nop && !hazard && free_valid;
  assign stall    = in_hold && !is_nop && !dispatch;

  always_comb begin
    unit_valid = '0;
    if (dispatch) unit_valid[free_idx] = 1'b1;
  end

  assign bus.issuer_rd_queue = pop;
  assign bus.o_unit_valid    = unit_valid;
  assign bus.o_unit_cmd      = dispatch ? held_q : '0;
  assign bus.finished_task   = fin_q;
  assign bus.o_stall_cycles  = stall_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_FETCH;
      active_q <= 1'b0;
      seen_q   <= 1'b0;
      held_q   <= '0;
      stall_q  <= '0;
      fin_q    <= 1'b0;
    end else begin
      active_q <= 1'b1;
      case (state_q)
        S_FETCH: begin
          if (pop) begin
            held_q  <= bus.queue_cmd;
            seen_q  <= 1'b1;
            state_q <= S_HOLD;
          end
        end
        default: begin
          if (is_nop || dispatch) state_q <= S_FETCH;
        end
      endcase
      if (stall && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      fin_q <= seen_q && (state_q == S_FETCH) && bus.queue_empty && !busy;
    end
  end

endmodule

// File: tb/tb_cmd_issuer.sv
// Directed bench for cmd_issuer: cycle model of the issue rules plus literal
// expectations on dispatch timing, unit choice, stall counts and drain.
module tb_cmd_issuer;
  import cmd_pkg::*;

  localparam int NU = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  cmd_issuer_if #(.NUM_UNITS(NU)) bus ();

  cmd_issuer #(.NUM_UNITS(NU)) dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stimulus side FIFO ----------------
  cmd_t tb_q[$];

  task automatic drive_q();
    bus.queue_empty = (tb_q.size() == 0);
    bus.queue_cmd   = (tb_q.size() != 0) ? tb_q[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.i_unit_done = '0;
    drive_q();
  endtask

  task automatic push(input cmd_t c);
    tb_q.push_back(c);
    drive_q();
  endtask

  task automatic pulse_done(input logic [NU-1:0] mask);
    bus.i_unit_done = mask;
    tick();
  endtask

  function automatic cmd_t mk(input op_e op, input int a, input int b, input int d, input int len);
    cmd_t c;
    c.op    = op;
    c.src_a = ADDR_W'(a);
    c.src_b = ADDR_W'(b);
    c.dst   = ADDR_W'(d);
    c.len   = LEN_W'(len);
    return c;
  endfunction

  // ---------------- behavioural model ----------------
  // Regions are sets of word addresses; a conflict is any shared word.
  function automatic bit share_word(input int lo_a, input int len_a, input int lo_b, input int len_b);
    for (int w = lo_a; w < lo_a + len_a; w++)
      if (w >= lo_b && w < lo_b + len_b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit conflicts(input cmd_t h, input cmd_t e);
    int hl, el;
    hl = int'(h.len);
    el = int'(e.len);
    return share_word(int'(e.dst), el, int'(h.src_a), hl) ||
           share_word(int'(e.dst), el, int'(h.src_b), hl) ||
           share_word(int'(h.dst), hl, int'(e.src_a), el) ||
           share_word(int'(h.dst), hl, int'(e.src_b), el) ||
           share_word(int'(h.dst), hl, int'(e.dst), el);
  endfunction

  bit     m_active, m_holding, m_seen, m_fin;
  cmd_t   m_held;
  bit     m_busy [NU];
  cmd_t   m_ent  [NU];
  longint m_stall;

  int             m_free;
  bit             m_haz, m_disp, m_stl, m_rd, m_any;
  logic [NU-1:0]  m_valid;
  cmd_t           m_cmd;

  int pop_log[$];
  int disp_cyc[$];
  int disp_unit[$];

  task automatic clear_logs();
    pop_log.delete();
    disp_cyc.delete();
    disp_unit.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rd",    bus.issuer_rd_queue, 0);
      chk("rst_valid", bus.o_unit_valid, 0);
      chk("rst_cmd",   bus.o_unit_cmd, 0);
      chk("rst_fin",   bus.finished_task, 0);
      chk("rst_stall", bus.o_stall_cycles, 0);
      m_active = 0; m_holding = 0; m_seen = 0; m_fin = 0; m_stall = 0;
      m_held = '0;
      for (int k = 0; k < NU; k++) begin m_busy[k] = 0; m_ent[k] = '0; end
    end else begin
      m_free = -1;
      for (int k = 0; k < NU; k++) if (!m_busy[k] && m_free < 0) m_free = k;
      m_haz = 0;
      for (int k = 0; k < NU; k++) if (m_busy[k] && conflicts(m_held, m_ent[k])) m_haz = 1;
      m_rd   = m_active && !m_holding && !bus.queue_empty;
      m_disp = m_holding && (m_held.op != OP_NOP) && !m_haz && (m_free >= 0);
      m_stl  = m_holding && (m_held.op != OP_NOP) && !m_disp;
      m_valid = '0;
      m_cmd   = '0;
      if (m_disp) begin m_valid[m_free] = 1'b1; m_cmd = m_held; end

      chk("rd",    bus.issuer_rd_queue, m_rd);
      chk("valid", bus.o_unit_valid, m_valid);
      chk("cmd",   bus.o_unit_cmd, m_cmd);
      chk("fin",   bus.finished_task, m_fin);
      chk("stall", bus.o_stall_cycles, m_stall);

      if (bus.issuer_rd_queue) pop_log.push_back(cyc);
      for (int k = 0; k < NU; k++)
        if (bus.o_unit_valid[k]) begin disp_cyc.push_back(cyc); disp_unit.push_back(k); end

      m_any = 0;
      for (int k = 0; k < NU; k++) if (m_busy[k]) m_any = 1;
      m_fin = m_seen && !m_holding && bus.queue_empty && !m_any;
      for (int k = 0; k < NU; k++) if (bus.i_unit_done[k]) m_busy[k] = 0;
      if (m_disp) begin m_busy[m_free] = 1; m_ent[m_free] = m_held; end
      if (m_holding && (m_held.op == OP_NOP || m_disp)) m_holding = 0;
      if (m_rd) begin
        m_held = tb_q.pop_front();
        m_holding = 1;
        m_seen = 1;
      end
      if (m_stl && m_stall != 64'hFFFF_FFFF) m_stall++;
      m_active = 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int st0;
  int done_cyc;

  task automatic apply_reset();
    rst_n = 1'b0;
    tb_q.delete();
    drive_q();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.queue_empty = 1'b1;
    bus.queue_cmd   = '0;
    bus.i_unit_done = '0;
    apply_reset();
    repeat (2) tick();

    // 1: three independent commands, pop counted as cycle 1 -> dispatch on cycles 2/4/6
    clear_logs();
    push(mk(OP_ADD, 12'h100, 12'h110, 12'h000, 4));
    push(mk(OP_MUL, 12'h120, 12'h130, 12'h010, 4));
    push(mk(OP_MAC, 12'h140, 12'h150, 12'h020, 4));
    repeat (8) tick();
    chk("t1_ndisp", disp_unit.size(), 3);
    if (disp_unit.size() == 3 && pop_log.size() >= 1) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_unit", disp_unit[i], i);
        chk("t1_gap",  disp_cyc[i] - pop_log[0], 2 * i + 1);
      end
    end
    chk("t1_stall", bus.o_stall_cycles, 0);
    pulse_done(4'b0111);
    tick();
    chk("t1_fin", bus.finished_task, 1);

    // 2: RAW, B reads a word A writes
    clear_logs();
    st0 = int'(bus.o_stall_cycles);
    push(mk(OP_ADD, 12'h200, 12'h210, 12'h040, 4));
    push(mk(OP_ADD, 12'h042, 12'h220, 12'h060, 4));
    repeat (6) tick();
    done_cyc = cyc;
    pulse_done(4'b0001);
    tick();
    chk("t2_ndisp", disp_unit.size(), 2);
    if (disp_unit.size() == 2) begin
      chk("t2_unit", disp_unit[1], 0);
      chk("t2_after_done", disp_cyc[1] - done_cyc, 1);
    end
    chk("t2_stall", int'(bus.o_stall_cycles) - st0, 4);
    pulse_done(4'b0001);

    // 3: adjacent regions and an empty region never conflict
    clear_logs();
    st0 = int'(bus.o_stall_cycles);
    push(mk(OP_ADD, 12'h300, 12'h310, 12'h040, 4));
    push(mk(OP_ADD, 12'h044, 12'h320, 12'h070, 4));
    push(mk(OP_MUL, 12'h040, 12'h045, 12'h041, 0));
    repeat (8) tick();
    chk("t3_ndisp", disp_unit.size(), 3);
    if (disp_unit.size() == 3) begin
      chk("t3_unit_b", disp_unit[1], 1);
      chk("t3_unit_c", disp_unit[2], 2);
      chk("t3_gap_b", disp_cyc[1] - disp_cyc[0], 2);
      chk("t3_gap_c", disp_cyc[2] - disp_cyc[1], 2);
    end
    chk("t3_stall", int'(bus.o_stall_cycles) - st0, 0);
    pulse_done(4'b0111);

    // 4: pool full; a done on an idle unit is ignored, then unit 2 frees
    pulse_done(4'b1000);
    clear_logs();
    st0 = int'(bus.o_stall_cycles);
    for (int i = 0; i < 5; i++)
      push(mk(OP_ADD, 12'h200 + 16 * i, 12'h280 + 16 * i, 12'h100 + 16 * i, 4));
    repeat (12) tick();
    chk("t4_ndisp_full", disp_unit.size(), 4);
    done_cyc = cyc;
    pulse_done(4'b0100);
    tick();
    chk("t4_ndisp", disp_unit.size(), 5);
    if (disp_unit.size() == 5) begin
      chk("t4_unit", disp_unit[4], 2);
      chk("t4_after_done", disp_cyc[4] - done_cyc, 1);
    end
    chk("t4_stall", int'(bus.o_stall_cycles) - st0, 4);
    pulse_done(4'b1111);
    tick();

    // 5: drain after a NOP and two real commands
    apply_reset();
    repeat (5) tick();
    chk("t5_fin_idle", bus.finished_task, 0);
    clear_logs();
    push(mk(OP_NOP, 12'h000, 12'h000, 12'h000, 4));
    push(mk(OP_ADD, 12'h200, 12'h210, 12'h010, 4));
    push(mk(OP_ADD, 12'h220, 12'h230, 12'h020, 4));
    repeat (8) tick();
    chk("t5_ndisp", disp_unit.size(), 2);
    chk("t5_fin_busy2", bus.finished_task, 0);
    pulse_done(4'b0001);
    tick();
    chk("t5_fin_busy1", bus.finished_task, 0);
    pulse_done(4'b0010);
    chk("t5_fin_edge", bus.finished_task, 0);
    tick();
    chk("t5_fin_set", bus.finished_task, 1);

    // 6: reset while holding with two units busy
    clear_logs();
    push(mk(OP_ADD, 12'h300, 12'h310, 12'h000, 4));
    push(mk(OP_ADD, 12'h320, 12'h330, 12'h010, 4));
    push(mk(OP_ADD, 12'h002, 12'h340, 12'h050, 4));
    repeat (7) tick();
    chk("t6_ndisp_pre", disp_unit.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.o_unit_valid, 0);
    chk("t6_rst_rd", bus.issuer_rd_queue, 0);
    chk("t6_rst_fin", bus.finished_task, 0);
    chk("t6_rst_stall", bus.o_stall_cycles, 0);
    tb_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    pulse_done(4'b0011);
    clear_logs();
    push(mk(OP_MAC, 12'h360, 12'h370, 12'h080, 4));
    repeat (4) tick();
    chk("t6_ndisp", disp_unit.size(), 1);
    if (disp_unit.size() == 1) chk("t6_unit", disp_unit[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
